// File: rtl/trap_pkg.sv
// Shared types and constants for the trapezoid scaling and peak capture stages.
// Sample width and saturation code are common to both stages.
package trap_pkg;

    localparam int DATA_W = 14;

    localparam logic signed [DATA_W-1:0] SAT_VALUE = 14'sd8191;

    typedef enum logic [1:0] {
        ARMED   = 2'd0,
        TRACK   = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

endpackage

// File: rtl/trap_peak_capture.sv
// Pulse-height extractor: threshold trigger, flat-top maximum, noise reject,
// pile-up flag, hold-off dead time and event counter.
module trap_peak_capture
    import trap_pkg::*;
#(
    parameter logic signed [13:0] THRESHOLD = 14'sd100,
    parameter int MIN_WIDTH = 4,
    parameter int MAX_WIDTH = 255,
    parameter int HOLDOFF   = 16
) (
    input  logic                     SYS_CLK,
    input  logic                     RESET_N,
    input  logic signed [DATA_W-1:0] DATAIN,
    input  logic                     OVERFLOW_IN,
    output logic signed [DATA_W-1:0] PEAK_HEIGHT,
    output logic                     PEAK_VALID,
    output logic                     SATURATED,
    output logic                     PILEUP,
    output logic                     BUSY,
    output logic [15:0]              EVENT_COUNT
);

    localparam logic [1:0] S_ARMED = trap_pkg::ARMED;
    localparam logic [1:0] S_TRACK = trap_pkg::TRACK;
    localparam logic [1:0] S_HOLD  = trap_pkg::HOLDOFF;

    localparam logic [7:0]  MIN_W    = 8'(MIN_WIDTH);
    localparam logic [7:0]  MAX_W    = 8'(MAX_WIDTH);
    localparam logic [15:0] HOLD_CNT = 16'(HOLDOFF);

    logic [1:0]               state;
    logic [7:0]               width;
    logic signed [DATA_W-1:0] max_q;
    logic                     sat_q;
    logic [15:0]              counter;

    logic       above;
    logic [7:0] width_inc;

    assign above     = DATAIN > THRESHOLD;
    assign width_inc = width + 8'd1;

    always_ff @(posedge SYS_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= S_ARMED;
            width       <= '0;
            max_q       <= '0;
            sat_q       <= 1'b0;
            counter     <= '0;
            PEAK_HEIGHT <= '0;
            PEAK_VALID  <= 1'b0;
            SATURATED   <= 1'b0;
            PILEUP      <= 1'b0;
            BUSY        <= 1'b0;
            EVENT_COUNT <= '0;
        end else begin
            PEAK_VALID <= 1'b0;
            SATURATED  <= 1'b0;
            PILEUP     <= 1'b0;
            unique case (1'b1)
                (state == S_ARMED): begin
                    if (above) begin
                        state <= S_TRACK;
                        width <= 8'd1;
                        max_q <= DATAIN;
                        sat_q <= OVERFLOW_IN;
                        BUSY  <= 1'b1;
                    end
                end
                (state == S_TRACK): begin
                    if (above) begin
                        // pile-up wins over the max/sat bookkeeping
                        if (width_inc == MAX_W) begin
                            PILEUP  <= 1'b1;
                            counter <= HOLD_CNT;
                            state   <= S_HOLD;
                        end else begin
                            width <= width_inc;
                            sat_q <= sat_q | OVERFLOW_IN;
                            if (DATAIN > max_q) begin
                                max_q <= DATAIN;
                            end
                        end
                    end else if (width >= MIN_W) begin
                        PEAK_HEIGHT <= sat_q ? SAT_VALUE : max_q;
                        SATURATED   <= sat_q;
                        PEAK_VALID  <= 1'b1;
                        EVENT_COUNT <= EVENT_COUNT + 16'd1;
                        counter     <= HOLD_CNT;
                        state       <= S_HOLD;
                    end else begin
                        state <= S_ARMED;
                        BUSY  <= 1'b0;
                    end
                end
                (state == S_HOLD): begin
                    counter <= counter - 16'd1;
                    if (counter == 16'd1) begin
                        state <= S_ARMED;
                        BUSY  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_ARMED;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule
